// File: rtl/bitty_pkg.sv
// Purpose: shared types and constants for the Bitty execution core.
// Contents: FSM state enum, instruction format codes, ALU op codes.
package bitty_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam logic [1:0] FMT_RR = 2'b00;
  localparam logic [1:0] FMT_RI = 2'b01;

  localparam logic [3:0] OP_ADD     = 4'd0;
  localparam logic [3:0] OP_SUB     = 4'd1;
  localparam logic [3:0] OP_AND     = 4'd2;
  localparam logic [3:0] OP_OR      = 4'd3;
  localparam logic [3:0] OP_XOR     = 4'd4;
  localparam logic [3:0] OP_SHL     = 4'd5;
  localparam logic [3:0] OP_SHR     = 4'd6;
  localparam logic [3:0] OP_CMP     = 4'd7;
  localparam logic [3:0] OP_MOV_MIN = 4'd8;

endpackage

// File: rtl/bitty_alu_p.sv
// Purpose: combinational Bitty ALU.
// Ports:
//   a    in  WIDTH  first operand (S latch)
//   b    in  WIDTH  second operand (register or immediate)
//   sel  in  4      operation select; 8..15 all decode as MOV
//   y    out WIDTH  result
//   cout out 1      carry (ADD) or borrow (SUB); 0 for other ops
module bitty_alu_p
  import bitty_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] y,
  output logic             cout
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  logic [WIDTH:0]  sum;
  logic [WIDTH:0]  diff;
  logic [SH_W-1:0] shamt;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    // Top bit of the widened difference is set exactly when a < b.
    diff  = {1'b0, a} - {1'b0, b};
    shamt = b[SH_W-1:0];
    y     = '0;
    cout  = 1'b0;
    case (sel)
      OP_ADD: begin
        y    = sum[WIDTH-1:0];
        cout = sum[WIDTH];
      end
      OP_SUB: begin
        y    = diff[WIDTH-1:0];
        cout = diff[WIDTH];
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SHL: y = a << shamt;
      OP_SHR: y = a >> shamt;
      OP_CMP: begin
        if (a == b)     y = '0;
        else if (a > b) y = WIDTH'(1);
        else            y = WIDTH'(2);
      end
      default: y = b;
    endcase
  end

endmodule

// File: rtl/bitty_core_p.sv
// Purpose: multi-cycle Bitty execution core (IDLE -> LOAD -> EXEC -> WB).
// Ports:
//   clk          in  1            clock, rising edge
//   reset        in  1            asynchronous active-high reset
//   instr        in  INSTR_W      instruction word, latched on accept
//   instr_valid  in  1            instr is valid
//   instr_ready  out 1            core idle and able to accept
//   done         out 1            one-cycle retire pulse (WB state)
//   carry        out 1            carry/borrow of last retired ADD/SUB
//   reg_c        out WIDTH        C result register
//   reg_flat     out NREGS*WIDTH  register file, R[i] at [i*WIDTH +: WIDTH]
module bitty_core_p
  import bitty_pkg::*;
#(
  parameter  int unsigned WIDTH   = 16,
  parameter  int unsigned NREGS   = 8,
  localparam int unsigned RIDX_W  = $clog2(NREGS),
  localparam int unsigned INSTR_W = 2*RIDX_W + 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INSTR_W-1:0]     instr,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  output logic                   done,
  output logic                   carry,
  output logic [WIDTH-1:0]       reg_c,
  output logic [NREGS*WIDTH-1:0] reg_flat
);

  localparam int unsigned IMM_W = INSTR_W - RIDX_W - 6;

  state_t             state_q;
  logic [INSTR_W-1:0] ir_q;
  logic [WIDTH-1:0]   regs_q [NREGS];
  logic [WIDTH-1:0]   s_q;
  logic [WIDTH-1:0]   c_q;
  logic               carry_q;

  logic [RIDX_W-1:0]  rx;
  logic [RIDX_W-1:0]  ry;
  logic [1:0]         fmt;
  logic [3:0]         alu_sel;
  logic [IMM_W-1:0]   imm;
  logic               is_op;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   alu_y;
  logic               alu_cout;

  // Field decode from the latched instruction; imm overlaps ry.
  assign rx      = ir_q[INSTR_W-1 -: RIDX_W];
  assign ry      = ir_q[INSTR_W-RIDX_W-1 -: RIDX_W];
  assign imm     = ir_q[INSTR_W-RIDX_W-1:6];
  assign fmt     = ir_q[1:0];
  assign alu_sel = ir_q[5:2];
  assign is_op   = (fmt == FMT_RR) || (fmt == FMT_RI);
  assign op_b    = (fmt == FMT_RI) ? WIDTH'(imm) : regs_q[ry];

  bitty_alu_p #(.WIDTH(WIDTH)) u_alu (
    .a    (s_q),
    .b    (op_b),
    .sel  (alu_sel),
    .y    (alu_y),
    .cout (alu_cout)
  );

  // Sequencer and datapath state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
      s_q     <= '0;
      c_q     <= '0;
      carry_q <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            ir_q    <= instr;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          s_q     <= regs_q[rx];
          state_q <= EXEC;
        end
        EXEC: begin
          if (is_op) begin
            c_q <= alu_y;
            if (alu_sel == OP_ADD || alu_sel == OP_SUB) carry_q <= alu_cout;
          end
          state_q <= WB;
        end
        default: begin
          if (is_op) regs_q[rx] <= c_q;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Handshake and retire flags are pure state decodes.
  assign instr_ready = (state_q == IDLE);
  assign done        = (state_q == WB);
  assign carry       = carry_q;
  assign reg_c       = c_q;

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign reg_flat[g*WIDTH +: WIDTH] = regs_q[g];
  end

endmodule
